// File: rtl/adc_fifo_read_arbiter.sv
// adc_fifo_read_arbiter
// Shares the single ADC FIFO read port (USB clock domain) between single-word
// register reads ("slow") and multi-word streaming bursts. Generates the FIFO
// read strobe, counts slow-read underflows and marks stream segment boundaries.
//
// Ports:
//   clk_usb, reset_i            clock, asynchronous active-high reset
//   fifo_empty / fifo_rd_en     FIFO status in, read strobe out (combinational)
//   slow_rd_req/_ack/_valid     single-word read request, service pulse, data-valid
//   burst_req/_len/_busy/_done  burst start, length, active flag, completion pulse
//   no_underflow_errors         suppresses underflow counting
//   clear_underflow             synchronous clear of underflow_count
//   underflow_count             saturating slow-underflow count
//   stream_segment_threshold    words per segment (0 = off)
//   segment_done                registered pulse at each segment boundary
//
// Optional feature: define FIFO_ARB_STARVE_GUARD_EN to let a pending slow read
// preempt a burst after pGUARD_WORDS burst reads; the burst then resumes.

module adc_fifo_read_arbiter #(
  parameter int unsigned pBURST_W     = 16,
  parameter int unsigned pGUARD_WORDS = 64
) (
  input  logic                clk_usb,
  input  logic                reset_i,
  input  logic                fifo_empty,
  output logic                fifo_rd_en,
  input  logic                slow_rd_req,
  output logic                slow_rd_ack,
  output logic                slow_rd_valid,
  input  logic                burst_req,
  input  logic [pBURST_W-1:0] burst_len,
  output logic                burst_busy,
  output logic                burst_done,
  input  logic                no_underflow_errors,
  input  logic                clear_underflow,
  output logic [7:0]          underflow_count,
  input  logic [16:0]         stream_segment_threshold,
  output logic                segment_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SLOW  = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_pending;
  logic                r_burst_active;
  logic [pBURST_W-1:0] r_words_left;
  logic [7:0]          r_underflow;
  logic [16:0]         r_seg_cnt;
  logic                r_segment_done;

  logic        w_in_slow;
  logic        w_in_burst;
  logic        w_words_zero;
  logic        w_slow_want;
  logic        w_guard_hit;
  logic [16:0] w_seg_next;

  assign w_in_slow    = (r_state == ST_SLOW);
  assign w_in_burst   = (r_state == ST_BURST);
  assign w_words_zero = (r_words_left == '0);
  // A slow read is wanted if one is already pending or arrives this cycle.
  assign w_slow_want  = r_pending | slow_rd_req;
  assign w_seg_next   = r_seg_cnt + 17'd1;

  // Read strobe and service pulses decode straight from state so the FIFO
  // sees the read in the same cycle the state is entered.
  assign fifo_rd_en      = ~fifo_empty & (w_in_slow | (w_in_burst & ~w_words_zero));
  assign slow_rd_ack     = w_in_slow;
  assign slow_rd_valid   = w_in_slow & ~fifo_empty;
  assign burst_done      = w_in_burst & w_words_zero;
  assign burst_busy      = r_burst_active;
  assign underflow_count = r_underflow;
  assign segment_done    = r_segment_done;

`ifdef FIFO_ARB_STARVE_GUARD_EN
  localparam int unsigned GUARD_W = $clog2(pGUARD_WORDS + 1);

  logic [GUARD_W-1:0] r_guard_cnt;

  // Preempt once the guard count is (or is just becoming) pGUARD_WORDS.
  assign w_guard_hit = w_in_burst & w_slow_want &
                       ((r_guard_cnt == GUARD_W'(pGUARD_WORDS)) |
                        (fifo_rd_en & (r_guard_cnt == GUARD_W'(pGUARD_WORDS - 1))));

  // Consecutive burst reads since entering BURST, saturating at the guard.
  always_ff @(posedge clk_usb or posedge reset_i) begin
    if (reset_i) begin
      r_guard_cnt <= '0;
    end else if (!w_in_burst) begin
      r_guard_cnt <= '0;
    end else if (fifo_rd_en && (r_guard_cnt != GUARD_W'(pGUARD_WORDS))) begin
      r_guard_cnt <= r_guard_cnt + GUARD_W'(1);
    end
  end
`else
  logic w_unused_guard;
  assign w_unused_guard = (pGUARD_WORDS == 0);
  assign w_guard_hit    = 1'b0;
`endif

  // Arbitration FSM
  always_ff @(posedge clk_usb or posedge reset_i) begin
    if (reset_i) begin
      r_state        <= ST_IDLE;
      r_pending      <= 1'b0;
      r_burst_active <= 1'b0;
      r_words_left   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_slow_want) begin
            r_state   <= ST_SLOW;
            r_pending <= 1'b0;
            // A burst arriving with the winning slow read is loaded now and
            // starts straight after SLOW via burst_active.
            if (burst_req) begin
              r_words_left   <= burst_len;
              r_burst_active <= 1'b1;
            end
          end else if (burst_req) begin
            r_state        <= ST_BURST;
            r_words_left   <= burst_len;
            r_burst_active <= 1'b1;
          end
        end
        ST_SLOW: begin
          r_pending <= r_pending | slow_rd_req;
          r_state   <= r_burst_active ? ST_BURST : ST_IDLE;
        end
        ST_BURST: begin
          if (w_words_zero) begin
            r_burst_active <= 1'b0;
            r_pending      <= 1'b0;
            r_state        <= w_slow_want ? ST_SLOW : ST_IDLE;
          end else begin
            if (fifo_rd_en) begin
              r_words_left <= r_words_left - pBURST_W'(1);
            end
            if (w_guard_hit) begin
              r_state   <= ST_SLOW;
              r_pending <= 1'b0;
            end else begin
              r_pending <= w_slow_want;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Slow-read underflow counter; clear wins over increment.
  always_ff @(posedge clk_usb or posedge reset_i) begin
    if (reset_i) begin
      r_underflow <= '0;
    end else if (clear_underflow) begin
      r_underflow <= '0;
    end else if (w_in_slow && fifo_empty && !no_underflow_errors &&
                 (r_underflow != 8'hFF)) begin
      r_underflow <= r_underflow + 8'd1;
    end
  end

  // Segment counter over all FIFO reads; pulses and rewinds at the threshold.
  always_ff @(posedge clk_usb or posedge reset_i) begin
    if (reset_i) begin
      r_seg_cnt      <= '0;
      r_segment_done <= 1'b0;
    end else if (fifo_rd_en) begin
      if ((stream_segment_threshold != 17'd0) &&
          (w_seg_next == stream_segment_threshold)) begin
        r_seg_cnt      <= '0;
        r_segment_done <= 1'b1;
      end else begin
        r_seg_cnt      <= w_seg_next;
        r_segment_done <= 1'b0;
      end
    end else begin
      r_segment_done <= 1'b0;
    end
  end

endmodule
